// File: rtl/riscv_mem_pkg.sv
// Shared definitions for riscv_memory_ws and its load/store alignment helper.
//   - Access size encodings carried on req_size.
//   - Data-port FSM state encoding.
//   - Instruction word returned for out-of-range fetches.
package riscv_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the data port of riscv_memory_ws.
// Ports:
//   size        access size (SZ_B / SZ_H / SZ_W; 2'b11 gives an empty mask)
//   addr_lo     byte offset within the word
//   data_in     right-aligned store data
//   rdata       full memory word being loaded
//   is_unsigned zero-extend sub-word loads
//   byte_mask   lanes written by a store
//   wdata       store data replicated into every candidate lane
//   load_data   selected lane shifted to bit 0 and extended
//   misaligned  half on odd address or word not on a 4-byte boundary
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data_in,
  input  logic [31:0] rdata,
  input  logic        is_unsigned,
  output logic [3:0]  byte_mask,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    byte_mask  = 4'b0000;
    wdata      = data_in;
    load_data  = '0;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        byte_mask = 4'b0001 << addr_lo;
        // Replicating lets the mask alone pick the destination lane.
        wdata     = {4{data_in[7:0]}};
        load_data = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        misaligned = addr_lo[0];
        byte_mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{data_in[15:0]}};
        load_data  = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SZ_W: begin
        misaligned = (addr_lo != 2'b00);
        byte_mask  = 4'b1111;
        wdata      = data_in;
        load_data  = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_memory_ws.sv
// Unified instruction/data memory with a wait-stated data port.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   inst_addr     instruction byte address (bits [1:0] ignored)
//   inst_out      combinational instruction word, NOP when out of range
//   req_valid     data request valid; taken when req_ready is also high
//   req_ready     high only in IDLE
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 rejected
//   req_unsigned  zero-extend sub-word loads
//   data_addr     data byte address
//   data_in       right-aligned store data
//   resp_valid    one-cycle response strobe, DATA_WAIT+1 cycles after acceptance
//   data_out      load result (0 for stores and errors)
//   resp_err      misaligned, out-of-range or bad-size access
module riscv_memory_ws
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned DATA_WAIT   = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_out,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic        resp_valid,
  output logic [31:0] data_out,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        write_q, write_d;
  logic        uns_q, uns_d;
  logic [31:0] data_out_q, data_out_d;
  logic        resp_err_q, resp_err_d;

  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  cur_size;
  logic        cur_write, cur_uns;
  logic [AW-1:0] cur_idx;
  logic [31:0] rdata;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata, lane_ldata;
  logic        misaligned, out_of_range, err;
  logic        enter_resp, mem_we;

  logic [AW-1:0] inst_idx;
  logic          inst_in_range;

  // Preloading is done by the integration flow; the parameter only names the image.
  logic unused_init;
  logic unused_inst_lo;
  assign unused_init    = (INIT_FILE != "");
  assign unused_inst_lo = ^inst_addr[1:0];

  // With DATA_WAIT==0 the memory is touched on the accepting edge, so use the live
  // request in IDLE and the latched one otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr  = data_addr;
      cur_wdata = data_in;
      cur_size  = req_size;
      cur_write = req_write;
      cur_uns   = req_unsigned;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_size  = size_q;
      cur_write = write_q;
      cur_uns   = uns_q;
    end
  end

  assign cur_idx      = cur_addr[AW+1:2];
  assign rdata        = mem_q[cur_idx];
  assign out_of_range = ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS);
  assign err          = (cur_size == 2'b11) || misaligned || out_of_range;

  lsu_align u_lsu_align (
    .size        (cur_size),
    .addr_lo     (cur_addr[1:0]),
    .data_in     (cur_wdata),
    .rdata       (rdata),
    .is_unsigned (cur_uns),
    .byte_mask   (lane_mask),
    .wdata       (lane_wdata),
    .load_data   (lane_ldata),
    .misaligned  (misaligned)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    write_d    = write_q;
    uns_d      = uns_q;
    data_out_d = '0;
    resp_err_d = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = data_addr;
          wdata_d = data_in;
          size_d  = req_size;
          write_d = req_write;
          uns_d   = req_unsigned;
          if (DATA_WAIT == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            // DATA_WAIT is limited to 0..15, so the counter width suffices.
            cnt_d   = 4'(DATA_WAIT);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      resp_err_d = err;
      data_out_d = (err || cur_write) ? 32'h0 : lane_ldata;
    end
  end

  // rst gates the write so a reset edge cannot complete an in-flight store.
  assign mem_we = enter_resp && cur_write && !err && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_out_q <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      resp_err_q <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    size_q  <= size_d;
    write_q <= write_d;
    uns_q   <= uns_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_mask[b]) begin
          mem_q[cur_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
        end
      end
    end
  end

  assign inst_in_range = ({2'b00, inst_addr[31:2]} < DEPTH_WORDS);
  assign inst_idx      = inst_addr[AW+1:2];
  assign inst_out      = inst_in_range ? mem_q[inst_idx] : NOP_INSN;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign data_out   = data_out_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_riscv_memory_ws.sv
module tb_riscv_memory_ws;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: DATA_WAIT=2 instance, index 1: DATA_WAIT=0 instance.
  logic        rst          [2];
  logic [31:0] inst_addr    [2];
  logic [31:0] inst_out     [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_write    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] data_addr    [2];
  logic [31:0] data_in      [2];
  logic        resp_valid   [2];
  logic [31:0] data_out     [2];
  logic        resp_err     [2];

  riscv_memory_ws #(.DEPTH_WORDS(DEPTH), .DATA_WAIT(2)) dut (
    .clk(clk), .rst(rst[0]), .inst_addr(inst_addr[0]), .inst_out(inst_out[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .data_addr(data_addr[0]),
    .data_in(data_in[0]), .resp_valid(resp_valid[0]), .data_out(data_out[0]),
    .resp_err(resp_err[0])
  );

  riscv_memory_ws #(.DEPTH_WORDS(DEPTH), .DATA_WAIT(0)) dut0 (
    .clk(clk), .rst(rst[1]), .inst_addr(inst_addr[1]), .inst_out(inst_out[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .data_addr(data_addr[1]),
    .data_in(data_in[1]), .resp_valid(resp_valid[1]), .data_out(data_out[1]),
    .resp_err(resp_err[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Byte-addressed reference memory per instance.
  logic [7:0] mdl [2][4*DEPTH];

  typedef struct {
    bit          err;
    logic [31:0] data;
    logic [31:0] iaddr;
    logic [31:0] inst;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic int dw(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] mdl_word(int d, logic [31:0] a);
    int base;
    if ((a >> 2) >= 32'(DEPTH)) return NOP;
    base = int'(a & 32'hFFFF_FFFC);
    return {mdl[d][base+3], mdl[d][base+2], mdl[d][base+1], mdl[d][base]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request, wait for acceptance, and queue its expected response.
  task automatic issue(input int d, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd, input bit hold,
                       input bit push, output int acc);
    exp_t        e;
    bit          err;
    logic [31:0] ld;
    int          nb;
    int          n;
    @(negedge clk); #1;
    req_valid[d]    = 1'b1;
    req_write[d]    = wr;
    req_size[d]     = sz;
    req_unsigned[d] = uns;
    data_addr[d]    = a;
    data_in[d]      = wd;
    inst_addr[d]    = a;
    n = 0;
    while (!req_ready[d] && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready[d]) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: inst %0d got req_ready=0 expected 1", d);
      req_valid[d] = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    nb  = 1 << sz;
    err = (sz == 2'b11) || ((a % nb) != 0) || ((a >> 2) >= 32'(DEPTH));
    if (!err && wr && push) begin
      for (int i = 0; i < nb; i++) mdl[d][int'(a) + i] = wd[8*i +: 8];
    end
    ld = '0;
    if (!err && !wr) begin
      for (int i = 0; i < nb; i++) ld[8*i +: 8] = mdl[d][int'(a) + i];
      if (!uns && nb < 4 && ld[8*nb-1]) begin
        for (int i = nb; i < 4; i++) ld[8*i +: 8] = 8'hFF;
      end
    end
    e.err   = err;
    e.data  = ld;
    e.iaddr = a;
    e.inst  = mdl_word(d, a);
    e.cyc   = acc + 1 + dw(d);
    if (push) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    if (!hold) begin
      #1;
      req_valid[d] = 1'b0;
    end
  endtask

  task automatic drain(input int d);
    int n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (((d == 0) ? q0.size() : q1.size()) != 0) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: inst %0d got %0d pending expected 0", d,
               (d == 0) ? q0.size() : q1.size());
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    if (!resp_valid[d]) return;
    if (((d == 0) ? q0.size() : q1.size()) == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_resp: inst %0d got resp_valid=1 expected 0", d);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("resp_err%0d", d), {31'b0, resp_err[d]}, {31'b0, e.err});
    check($sformatf("data_out%0d", d), data_out[d], e.data);
    check($sformatf("latency%0d", d), 32'(cyc), 32'(e.cyc));
    if (inst_addr[d] == e.iaddr) check($sformatf("inst_out%0d", d), inst_out[d], e.inst);
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    int acc, acc_prev;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; inst_addr[d] = '0; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_size[d] = 2'b00; req_unsigned[d] = 1'b0; data_addr[d] = '0; data_in[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", {31'b0, req_ready[d]}, 32'd1);
      check("reset_resp_valid", {31'b0, resp_valid[d]}, 32'd0);
      check("reset_resp_err", {31'b0, resp_err[d]}, 32'd0);
      check("reset_data_out", data_out[d], 32'd0);
    end

    // Give every word a known value.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < int'(DEPTH); w++) issue(d, 1, 2'b10, 0, 32'(4*w), $urandom, 0, 1, acc);
      drain(d);
    end

    // Word store then load.
    issue(0, 1, 2'b10, 0, 32'h40, 32'hDEAD_BEEF, 0, 1, acc);
    issue(0, 0, 2'b10, 0, 32'h40, 32'h0, 0, 1, acc);
    drain(0);
    check("lw_0x40_value_via_model", mdl_word(0, 32'h40), 32'hDEAD_BEEF);

    // Byte lanes.
    issue(0, 1, 2'b10, 0, 32'h100, 32'h1122_3344, 0, 1, acc);
    issue(0, 1, 2'b00, 0, 32'h101, 32'h0000_00AB, 0, 1, acc);
    issue(0, 0, 2'b10, 0, 32'h100, 32'h0, 0, 1, acc);
    issue(0, 0, 2'b00, 0, 32'h101, 32'h0, 0, 1, acc);
    issue(0, 0, 2'b00, 1, 32'h101, 32'h0, 0, 1, acc);
    issue(0, 0, 2'b01, 0, 32'h102, 32'h0, 0, 1, acc);
    drain(0);
    @(negedge clk); #1;
    inst_addr[0] = 32'h100;
    #1;
    check("sb_word_inst", inst_out[0], 32'h1122_AB44);

    // Errors.
    issue(0, 0, 2'b10, 0, 32'h102, 32'h0, 0, 1, acc);
    issue(0, 1, 2'b01, 0, 32'h103, 32'hFFFF_FFFF, 0, 1, acc);
    issue(0, 0, 2'b10, 0, 32'h100, 32'h0, 0, 1, acc);
    issue(0, 0, 2'b10, 0, 32'(4*DEPTH), 32'h0, 0, 1, acc);
    issue(0, 0, 2'b11, 0, 32'h100, 32'h0, 0, 1, acc);
    drain(0);
    @(negedge clk); #1;
    inst_addr[0] = 32'(4*DEPTH);
    #1;
    check("inst_out_of_range", inst_out[0], NOP);

    // Busy: valid held high across two stores to the same word.
    issue(0, 1, 2'b10, 0, 32'h200, 32'hAAAA_0001, 1, 1, acc_prev);
    issue(0, 1, 2'b10, 0, 32'h200, 32'hBBBB_0002, 0, 1, acc);
    check("busy_spacing", 32'(acc - acc_prev), 32'd4);
    issue(0, 0, 2'b10, 0, 32'h200, 32'h0, 0, 1, acc);
    drain(0);
    check("busy_order_model", mdl_word(0, 32'h200), 32'hBBBB_0002);

    // Reset in the first WAIT cycle aborts the store.
    issue(0, 1, 2'b10, 0, 32'h80, 32'h55, 0, 0, acc);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, req_ready[0]}, 32'd1);
    repeat (4) @(negedge clk);
    issue(0, 0, 2'b10, 0, 32'h80, 32'h0, 0, 1, acc);
    drain(0);

    // DATA_WAIT=0: alternating sw/lw, one accept every two cycles.
    acc_prev = -1;
    for (int i = 0; i < 6; i++) begin
      issue(1, (i % 2) == 0, 2'b10, 0, 32'h40 + 32'(4*(i/2)), $urandom, i != 5, 1, acc);
      if (acc_prev >= 0) check("dw0_spacing", 32'(acc - acc_prev), 32'd2);
      acc_prev = acc;
    end
    drain(1);

    // Random traffic against the reference model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 120; i++) begin
        logic [31:0] a;
        logic [1:0]  sz;
        a  = ($urandom_range(0, 9) == 0) ? 32'(4*DEPTH) + 32'($urandom_range(0, 255))
                                         : 32'($urandom_range(0, 4*DEPTH-1));
        sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        issue(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
              1'($urandom_range(0, 1)), 1, acc);
        if ($urandom_range(0, 3) == 0) begin
          #1;
          req_valid[d] = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
      req_valid[d] = 1'b0;
      drain(d);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_memory_ws.md
Name: riscv_memory_ws

Overview:
- Parametrised successor to the unified instruction/data memory used by riscv_processor.
- Instruction port: asynchronous word read.
- Data port: valid/ready request, response after a configurable number of wait states, byte/halfword/word access with sign/zero extension, and error reporting for misaligned or out-of-range accesses.
- Lets the processor be verified against non-ideal memory timing.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; address range is 0 to 4*DEPTH_WORDS-1.
- DATA_WAIT, 2: wait cycles between request acceptance and response (0..15).
- INIT_FILE, "": optional $readmemh image loaded at elaboration; empty means contents undefined.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- inst_addr  input  32  instruction byte address; bits [1:0] ignored.
- inst_out  output  32  instruction word, combinational.
- req_valid  input  1  data request valid.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is an error.
- req_unsigned  input  1  zero-extend loads (lbu/lhu).
- data_addr  input  32  data byte address.
- data_in  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle response strobe.
- data_out  output  32  load result; valid only with resp_valid.
- resp_err  output  1  access rejected; valid only with resp_valid.

Behaviour:
- Reset:
  - FSM goes to IDLE; the wait counter clears.
  - resp_valid=0, resp_err=0, data_out=0. req_ready=1 from the first cycle after reset.
  - Memory contents are not cleared.
- States:
  - IDLE: req_ready=1.
  - WAIT: req_ready=0; counts down DATA_WAIT cycles.
  - RESP: req_ready=0, resp_valid=1 for exactly one cycle.
- Acceptance: a request is taken at an edge where req_valid && req_ready. At that edge the block latches addr, size, write, unsigned and data.
- Transitions:
  - IDLE to WAIT on acceptance when DATA_WAIT>0.
  - IDLE to RESP on acceptance when DATA_WAIT==0.
  - WAIT to RESP when the counter reaches 1.
  - RESP to IDLE always.
- Latency: accept at edge T; resp_valid high in cycle T+1+DATA_WAIT. Back-to-back throughput is one request per DATA_WAIT+2 cycles.
- req_valid is ignored while not in IDLE; there is no queueing.
- Error conditions, checked at acceptance:
  - req_size==11.
  - Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - Word index >= DEPTH_WORDS.
  - On error the FSM follows the same timing; resp_err=1, data_out=0, and there is no memory write.
- Stores:
  - Written on the edge entering RESP, using a byte-lane mask from size and addr[1:0]. Lanes outside the mask are unchanged.
  - data_out=0 on a store response.
- Loads:
  - Word read on the edge entering RESP.
  - Selected lane is shifted to bit 0, then sign-extended or zero-extended according to req_unsigned.
  - Word loads ignore req_unsigned.
- Instruction port:
  - inst_out = mem[inst_addr[31:2]].
  - Out of range returns 32'h00000013 (NOP).
  - A store to the same word appears on inst_out from the cycle after the write edge.
- Reset asserted mid-WAIT or mid-RESP aborts the request. No write is performed and no resp_valid is produced.

Decomposition:
- riscv_mem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W.
  - state encoding IDLE, WAIT, RESP.
  - NOP_INSN=32'h00000013.
- Sub-module lsu_align (combinational):
  - inputs size, addr[1:0], data_in, rdata, unsigned.
  - outputs byte mask, shifted write data, extended load data, misaligned flag.
- The FSM, counter and storage stay in riscv_memory_ws.

Test Plan:
- Word store then load (DATA_WAIT=2): sw 0xDEADBEEF to 0x40, then lw 0x40. resp_valid comes exactly 3 cycles after each accept; data_out=0xDEADBEEF; inst_addr=0x40 shows 0xDEADBEEF after the store edge.
- Byte lanes: preload 0x11223344 at 0x100, sb 0xAB to 0x101. The word reads 0x1122AB44; lb 0x101 gives 0xFFFFFFAB; lbu 0x101 gives 0x000000AB; lh 0x102 gives 0x00001122.
- Errors:
  - lw 0x102 gives resp_err=1, data_out=0.
  - sh 0x103 gives resp_err=1 and memory unchanged.
  - lw 4*DEPTH_WORDS gives resp_err=1.
  - size=11 gives resp_err=1.
- Busy handling: hold req_valid high continuously for two different sw requests. Only the first is accepted; the second is accepted only after RESP, and both writes land in order.
- Reset mid-WAIT: accept sw 0x55 to 0x80 and assert rst in the first WAIT cycle. No resp_valid, mem[0x80] unchanged, req_ready=1 in the cycle after rst deasserts.
- DATA_WAIT=0 build: lw returns resp_valid in cycle T+1; alternating sw/lw sustains one accept every 2 cycles.
